// File: rtl/axi_mem_tester_if.sv
// AXI4-Lite bus bundle between the BIST master and the SDRAM controller slave port.
interface axi_mem_tester_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_mem_tester.sv
// AXI4-Lite memory BIST master: writes a pattern over an address window, reads it
// back, and reports mismatches, error responses and stalled handshakes.
module axi_mem_tester #(
  parameter int unsigned        ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = ADDR_W'(32'h0100_0000),
  parameter int unsigned        NUM_WORDS = 16,
  parameter int unsigned        STRIDE    = 4,
  parameter int unsigned        TIMEOUT   = 1023,
  parameter int unsigned        ERR_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [1:0]           mode_i,
  axi_mem_tester_if.master     m_axi,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic                 timeout_o,
  output logic [ERR_W-1:0]     err_count_o,
  output logic [ADDR_W-1:0]    first_err_addr_o,
  output logic [31:0]          first_err_data_o
);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE} state_t;

  localparam logic [31:0]       LFSR_SEED = 32'hACE1_ACE1;
  localparam logic [31:0]       LFSR_TAPS = 32'h8020_0003;
  localparam int                TMO_W     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(TIMEOUT);
  localparam logic [15:0]       LAST_IDX  = 16'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(STRIDE);

  state_t            state_q, state_d;
  logic [15:0]       idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       lfsr_q, lfsr_d;
  logic [1:0]        mode_q, mode_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic              arvalid_q, arvalid_d, rready_q, rready_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d, timeout_q, timeout_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [ADDR_W-1:0] fea_q, fea_d;
  logic [31:0]       fed_q, fed_d;

  logic              beat_err, stalled, finish;
  logic [31:0]       err_data, expected;

  function automatic logic [31:0] pattern(input logic [1:0] m, input logic [ADDR_W-1:0] a,
                                          input logic [31:0] l);
    logic [31:0] a32;
    a32 = 32'(a);
    case (m)
      2'd0:    return a32;
      2'd1:    return ~a32;
      2'd2:    return l;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return {1'b0, l[31:1]} ^ (l[0] ? LFSR_TAPS : 32'h0);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      addr_q    <= '0;
      lfsr_q    <= '0;
      mode_q    <= '0;
      tmo_q     <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= '0;
      fea_q     <= '0;
      fed_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      lfsr_q    <= lfsr_d;
      mode_q    <= mode_d;
      tmo_q     <= tmo_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
      fea_q     <= fea_d;
      fed_q     <= fed_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    lfsr_d    = lfsr_q;
    mode_d    = mode_q;
    tmo_d     = tmo_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    err_d     = err_q;
    fea_d     = fea_q;
    fed_d     = fed_q;
    beat_err  = 1'b0;
    stalled   = 1'b0;
    finish    = 1'b0;
    err_data  = wdata_q;
    expected  = pattern(mode_q, addr_q, lfsr_q);

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d   = WR_REQ;
          mode_d    = mode_i;
          idx_d     = '0;
          addr_d    = BASE_ADDR;
          lfsr_d    = LFSR_SEED;
          wdata_d   = pattern(mode_i, BASE_ADDR, LFSR_SEED);
          wstrb_d   = 4'hF;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          tmo_d     = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          err_d     = '0;
          fea_d     = '0;
          fed_d     = '0;
        end
      end
      WR_REQ: begin
        // Address and data channels complete independently of each other.
        if (awvalid_q && m_axi.awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi.wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
          tmo_d    = '0;
        end else begin
          stalled = 1'b1;
        end
      end
      WR_RESP: begin
        if (m_axi.bvalid) begin
          bready_d = 1'b0;
          beat_err = (m_axi.bresp != 2'b00);
          tmo_d    = '0;
          if (idx_q == LAST_IDX) begin
            // Reseeding here makes the read phase regenerate the write sequence.
            state_d   = RD_REQ;
            idx_d     = '0;
            addr_d    = BASE_ADDR;
            lfsr_d    = LFSR_SEED;
            arvalid_d = 1'b1;
          end else begin
            state_d   = WR_REQ;
            idx_d     = idx_q + 16'd1;
            addr_d    = addr_q + STEP;
            lfsr_d    = lfsr_step(lfsr_q);
            wdata_d   = pattern(mode_q, addr_d, lfsr_d);
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end
        end else begin
          stalled = 1'b1;
        end
      end
      RD_REQ: begin
        if (m_axi.arready) begin
          state_d   = RD_DATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          tmo_d     = '0;
        end else begin
          stalled = 1'b1;
        end
      end
      RD_DATA: begin
        if (m_axi.rvalid) begin
          rready_d = 1'b0;
          beat_err = (m_axi.rdata != expected) || (m_axi.rresp != 2'b00);
          err_data = m_axi.rdata;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            finish  = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d   = RD_REQ;
            idx_d     = idx_q + 16'd1;
            addr_d    = addr_q + STEP;
            lfsr_d    = lfsr_step(lfsr_q);
            arvalid_d = 1'b1;
            tmo_d     = '0;
          end
        end else begin
          stalled = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (stalled) begin
      if (tmo_q == TMO_MAX) begin
        state_d   = DONE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b1;
        pass_d    = 1'b0;
        timeout_d = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    if (beat_err) begin
      if (err_q != '1) err_d = err_q + 1'b1;
      if (err_q == '0) begin
        fea_d = addr_q;
        fed_d = err_data;
      end
    end

    if (finish) pass_d = (err_d == '0);
  end

  assign m_axi.awaddr  = addr_q;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign timeout_o        = timeout_q;
  assign err_count_o      = err_q;
  assign first_err_addr_o = fea_q;
  assign first_err_data_o = fed_q;
endmodule

// File: tb/tb_axi_mem_tester.sv
// Directed bench for axi_mem_tester with a configurable AXI4-Lite memory slave model.
module tb_axi_mem_tester;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [1:0]  mode_i = 2'd0;
  logic        busy_o, done_o, pass_o, timeout_o;
  logic [1:0]  err_count_o;
  logic [31:0] first_err_addr_o, first_err_data_o;

  int checks = 0;
  int failures = 0;

  axi_mem_tester_if #(.ADDR_W(32)) bus ();

  axi_mem_tester #(
    .ADDR_W(32), .BASE_ADDR(32'h0100_0000), .NUM_WORDS(4),
    .STRIDE(4), .TIMEOUT(15), .ERR_W(2)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i), .m_axi(bus),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o),
    .err_count_o(err_count_o), .first_err_addr_o(first_err_addr_o),
    .first_err_data_o(first_err_data_o)
  );

  always #5 clk = ~clk;

  // Slave model behaviour knobs
  int   max_dly = 0;
  logic ar_block = 1'b0;
  logic bresp_bad = 1'b0;
  int   corrupt_idx = -1;

  logic [31:0] mem [0:15];
  logic        aw_got, w_got, b_pend, r_pend;
  logic [31:0] aw_a, w_d, r_data;
  int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;

  function automatic int rnd();
    return (max_dly == 0) ? 0 : int'($urandom_range(max_dly, 0));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - 32'h0100_0000) >> 2) & 15;
  endfunction

  wire aw_hs = bus.awvalid && bus.awready;
  wire w_hs  = bus.wvalid && bus.wready;
  wire ar_hs = bus.arvalid && bus.arready;

  assign bus.awready = (aw_cnt == 0);
  assign bus.wready  = (w_cnt == 0);
  assign bus.arready = (ar_cnt == 0) && !ar_block;
  assign bus.bvalid  = b_pend && (b_cnt == 0);
  assign bus.bresp   = bresp_bad ? 2'b10 : 2'b00;
  assign bus.rvalid  = r_pend && (r_cnt == 0);
  assign bus.rresp   = 2'b00;
  assign bus.rdata   = r_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      aw_a <= '0; w_d <= '0; r_data <= '0;
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
    end else begin
      if (aw_hs) aw_cnt <= rnd(); else if (aw_cnt != 0) aw_cnt <= aw_cnt - 1;
      if (w_hs)  w_cnt  <= rnd(); else if (w_cnt != 0)  w_cnt  <= w_cnt - 1;
      if (ar_hs) ar_cnt <= rnd(); else if (ar_cnt != 0) ar_cnt <= ar_cnt - 1;
      if (aw_hs) begin aw_got <= 1'b1; aw_a <= bus.awaddr; end
      if (w_hs)  begin w_got <= 1'b1;  w_d <= bus.wdata;   end
      if (b_pend && b_cnt != 0) b_cnt <= b_cnt - 1;
      if (bus.bvalid && bus.bready) b_pend <= 1'b0;
      if ((aw_got || aw_hs) && (w_got || w_hs)) begin
        mem[widx(aw_hs ? bus.awaddr : aw_a)] <= w_hs ? bus.wdata : w_d;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        b_pend <= 1'b1;
        b_cnt  <= rnd();
      end
      if (r_pend && r_cnt != 0) r_cnt <= r_cnt - 1;
      if (bus.rvalid && bus.rready) r_pend <= 1'b0;
      if (ar_hs) begin
        r_pend <= 1'b1;
        r_cnt  <= rnd();
        r_data <= mem[widx(bus.araddr)] ^ ((widx(bus.araddr) == corrupt_idx) ? 32'h1 : 32'h0);
      end
    end
  end

  // A valid that was stalled must still be high at the next edge unless aborted.
  logic aw_st = 1'b0, w_st = 1'b0, ar_st = 1'b0;
  int   drops = 0;
  always @(negedge clk) begin
    if (rst) begin
      aw_st <= 1'b0; w_st <= 1'b0; ar_st <= 1'b0;
    end else begin
      if (!timeout_o && ((aw_st && !bus.awvalid) || (w_st && !bus.wvalid) || (ar_st && !bus.arvalid)))
        drops <= drops + 1;
      aw_st <= bus.awvalid && !bus.awready;
      w_st  <= bus.wvalid && !bus.wready;
      ar_st <= bus.arvalid && !bus.arready;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, got, exp);
  endtask

  int   cyc;
  logic busy_at1, aw_at1;

  task automatic run_test(input logic [1:0] m, input int restart_at);
    @(negedge clk);
    start_i = 1'b1;
    mode_i  = m;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin busy_at1 = busy_o; aw_at1 = bus.awvalid; end
      start_i = (cyc == restart_at);
      if (cyc == restart_at) mode_i = 2'd3;
    end while (!done_o && cyc < 2000);
    $display("run mode=%0d cycles=%0d err=%0d pass=%0b", m, cyc, err_count_o, pass_o);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_done", {31'b0, done_o}, 32'd0);
    check("rst_valids", {27'b0, bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 32'd0);
    check("rst_awaddr", bus.awaddr, 32'd0);
    check("rst_wstrb", {28'b0, bus.wstrb}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Mode 0, zero-wait slave
    run_test(2'd0, 0);
    check("t1_cycles", cyc, 32'd17);
    check("t1_busy_n1", {31'b0, busy_at1}, 32'd1);
    check("t1_awv_n1", {31'b0, aw_at1}, 32'd1);
    check("t1_pass", {30'b0, pass_o, done_o}, 32'd3);
    check("t1_err", {30'b0, err_count_o}, 32'd0);
    check("t1_busy_end", {31'b0, busy_o}, 32'd0);
    check("t1_wstrb", {28'b0, bus.wstrb}, 32'hF);
    check("t1_mem0", mem[0], 32'h0100_0000);
    check("t1_mem1", mem[1], 32'h0100_0004);
    check("t1_mem2", mem[2], 32'h0100_0008);
    check("t1_mem3", mem[3], 32'h0100_000C);

    // Mode 1 with a start pulse while busy, which must be ignored
    run_test(2'd1, 5);
    check("t2_cycles", cyc, 32'd17);
    check("t2_pass", {31'b0, pass_o}, 32'd1);
    check("t2_mem1", mem[1], 32'hFEFF_FFFB);

    // Mode 2, random handshake delays
    max_dly = 5;
    run_test(2'd2, 0);
    check("t3_pass", {30'b0, pass_o, done_o}, 32'd3);
    check("t3_err", {30'b0, err_count_o}, 32'd0);
    check("t3_mem0", mem[0], 32'hACE1_ACE1);
    check("t3_mem1", mem[1], 32'hD650_D673);
    check("t3_mem2", mem[2], 32'hEB08_6B3A);
    check("t3_mem3", mem[3], 32'h7584_359D);
    check("t3_drops", drops, 32'd0);

    // Mode 3, slave corrupts word 2 on read
    max_dly = 0;
    corrupt_idx = 2;
    run_test(2'd3, 0);
    check("t4_done_pass", {30'b0, done_o, pass_o}, 32'd2);
    check("t4_err", {30'b0, err_count_o}, 32'd1);
    check("t4_fea", first_err_addr_o, 32'h0100_0008);
    check("t4_fed", first_err_data_o, 32'hFFFF_FFFE);
    corrupt_idx = -1;

    // Every write gets SLVERR; 4 errors saturate a 2-bit counter at 3
    bresp_bad = 1'b1;
    run_test(2'd0, 0);
    check("t5_done_pass", {30'b0, done_o, pass_o}, 32'd2);
    check("t5_timeout", {31'b0, timeout_o}, 32'd0);
    check("t5_err_sat", {30'b0, err_count_o}, 32'd3);
    check("t5_fea", first_err_addr_o, 32'h0100_0000);
    check("t5_fed", first_err_data_o, 32'h0100_0000);
    bresp_bad = 1'b0;

    // arready stuck low: abort 16 cycles after arvalid rises
    ar_block = 1'b1;
    @(negedge clk);
    start_i = 1'b1;
    mode_i  = 2'd0;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    n = 0;
    while (!bus.arvalid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t6_arvalid", {31'b0, bus.arvalid}, 32'd1);
    repeat (15) begin @(posedge clk); #1; end
    check("t6_done_early", {31'b0, done_o}, 32'd0);
    @(posedge clk);
    #1;
    check("t6_done_tmo", {30'b0, done_o, timeout_o}, 32'd3);
    check("t6_arv_pass", {30'b0, bus.arvalid, pass_o}, 32'd0);
    ar_block = 1'b0;

    // Reset while waiting on the first write response
    @(negedge clk);
    start_i = 1'b1;
    mode_i  = 2'd1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    n = 0;
    while (!bus.bready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t7_in_wresp", {31'b0, bus.bready}, 32'd1);
    rst = 1'b1;
    #1;
    check("t7_valids", {27'b0, bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 32'd0);
    check("t7_flags", {28'b0, busy_o, done_o, pass_o, timeout_o}, 32'd0);
    check("t7_awaddr", bus.awaddr, 32'd0);
    check("t7_wdata", bus.wdata, 32'd0);
    check("t7_err", {30'b0, err_count_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    max_dly = 3;
    run_test(2'd2, 0);
    check("t7_pass", {30'b0, pass_o, done_o}, 32'd3);
    check("t7_mem2", mem[2], 32'hEB08_6B3A);
    check("t7_drops", drops, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
